// File: rtl/mileage_recorder.sv
// Odometer source: counts driving time in distance units (one per TICK_DIV clocks in RUN).
// Define MILEAGE_WRAP_EN to wrap REC_MAX -> 0; by default the record saturates at REC_MAX.
module mileage_recorder #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned REC_MAX  = 99_999_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_now,
    input  logic        state1,
    input  logic        move_en,
    input  logic        clear_req,
    output logic [26:0] record,
    output logic        record_upd,
    output logic        at_max
);

    localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [26:0]      REC_TOP  = 27'(REC_MAX);

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [26:0]      record_q, record_d;
    logic             upd_q, upd_d;
    logic             at_max_q, at_max_d;
    logic             driving;
    logic             tick;

    assign driving = state1 & move_en;
    assign tick    = (state_q == S_RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_OFF:   if (power_now) state_d = S_IDLE;
            S_IDLE:  if (driving)   state_d = S_RUN;
            S_RUN:   if (!driving)  state_d = S_IDLE;
            default: state_d = S_OFF;
        endcase
        if (!power_now) state_d = S_OFF;
    end

    // Partial units are discarded whenever RUN is left or a clear is requested.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN) && !clear_req) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        record_d = record_q;
        upd_d    = 1'b0;
        if (!power_now || clear_req) begin
            record_d = '0;
            upd_d    = (record_q != '0);
        end else if (tick) begin
            if (record_q != REC_TOP) begin
                record_d = record_q + 27'd1;
                upd_d    = 1'b1;
            end else begin
`ifdef MILEAGE_WRAP_EN
                record_d = '0;
                upd_d    = 1'b1;
`else
                record_d = record_q;
                upd_d    = 1'b0;
`endif
            end
        end
        at_max_d = (record_d == REC_TOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            record_q <= '0;
            upd_q    <= 1'b0;
            at_max_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            record_q <= record_d;
            upd_q    <= upd_d;
            at_max_q <= at_max_d;
        end
    end

    assign record     = record_q;
    assign record_upd = upd_q;
    assign at_max     = at_max_q;

endmodule

// File: tb/tb_mileage_recorder.sv
// Scoreboard bench for mileage_recorder: a reference model predicts each cycle's outputs,
// a negedge monitor compares them. Honours MILEAGE_WRAP_EN like the design.
module tb_mileage_recorder;

    localparam int TICK = 4;
    localparam int RMAX = 9;
`ifdef MILEAGE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic [26:0] rec;
        logic        upd;
        logic        amax;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power_now, state1, move_en, clear_req;
    logic [26:0] record;
    logic        record_upd, at_max;

    int vectors    = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Reference model: session powered, currently driving, clocks of credit, mileage.
    bit m_on, m_moving;
    int m_credit, m_rec;

    mileage_recorder #(.TICK_DIV(TICK), .REC_MAX(RMAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .power_now  (power_now),
        .state1     (state1),
        .move_en    (move_en),
        .clear_req  (clear_req),
        .record     (record),
        .record_upd (record_upd),
        .at_max     (at_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Mileage changes exactly when a unit is earned, cleared or lost at power-off.
    task automatic model_step(input bit p, input bit s, input bit m, input bit c);
        exp_t e;
        int   new_rec;
        bit   tick;
        if (!rst_n) begin
            m_on = 0; m_moving = 0; m_credit = 0; m_rec = 0;
            e.rec = '0; e.upd = 1'b0; e.amax = 1'b0;
        end else begin
            tick = m_moving && (m_credit == TICK - 1);
            if (!p || c)      new_rec = 0;
            else if (tick)    new_rec = (m_rec < RMAX) ? m_rec + 1 : (WRAP ? 0 : RMAX);
            else              new_rec = m_rec;
            e.rec  = 27'(new_rec);
            e.upd  = (new_rec != m_rec);
            e.amax = (new_rec == RMAX);
            m_credit = (m_moving && p && s && m && !c) ? (tick ? 0 : m_credit + 1) : 0;
            m_moving = p && m_on && s && m;
            m_on     = p;
            m_rec    = new_rec;
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs (just after a posedge), predict the next edge's outcome.
    task automatic step(input bit p, input bit s, input bit m, input bit c);
        power_now = p; state1 = s; move_en = m; clear_req = c;
        @(posedge clk);
        model_step(p, s, m, c);
        #1;
    endtask

    task automatic run_until_rec(input int target, input bit need_tick, input string name);
        int n = 0;
        while (!(m_rec == target && (!need_tick || (m_moving && m_credit == TICK - 1))) && n < 200) begin
            step(1, 1, 1, 0);
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, 32'(n), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (record !== e.rec || record_upd !== e.upd || at_max !== e.amax) begin
                    miscompares++;
                    $display("FAIL cycle: record=%0d upd=%0b at_max=%0b, want record=%0d upd=%0b at_max=%0b (t=%0t)",
                             record, record_upd, at_max, e.rec, e.upd, e.amax, $time);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        power_now = 1'b0; state1 = 1'b0; move_en = 1'b0; clear_req = 1'b0;
        #1;
        check("reset_record", 32'(record), 32'd0);
        check("reset_upd",    32'(record_upd), 32'd0);
        check("reset_at_max", 32'(at_max), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;

        // Plain driving: three units, pulses four clocks apart.
        repeat (14) step(1, 1, 1, 0);

        // Async reset mid-RUN with record=5, then restart from OFF.
        run_until_rec(5, 1'b0, "reach5");
        repeat (2) step(1, 1, 1, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_record", 32'(record), 32'd0);
        check("async_rst_upd",    32'(record_upd), 32'd0);
        check("async_rst_at_max", 32'(at_max), 32'd0);
        step(1, 1, 1, 0);
        rst_n = 1'b1;
        repeat (8) step(1, 1, 1, 0);

        // Partial unit discarded on a one-clock stop.
        repeat (3) step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        repeat (6) step(1, 1, 1, 0);

        // Clear on the tick cycle at record=3, then held clear in RUN.
        run_until_rec(3, 1'b1, "reach3");
        step(1, 1, 1, 1);
        repeat (8) step(1, 1, 1, 1);

        // Boundary at REC_MAX: saturate or wrap.
        run_until_rec(RMAX, 1'b0, "reach_max");
        repeat (8) step(1, 1, 1, 0);
        repeat (6) step(1, 1, 1, 0);

        // Power-off with record=7, then no counting while unpowered.
        step(1, 1, 1, 1);
        run_until_rec(7, 1'b0, "reach7");
        step(0, 1, 1, 0);
        repeat (6) step(0, 1, 1, 0);

        // Randomized driving sessions.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 31) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 39) == 0);
        end

        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
